// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier.
//   MUL_MAX_STAGES    : deepest supported pipeline.
//   mul_sign_t        : per-operand signedness pair.
//   csa_rows_after()  : rows left after a number of CSA3T2 layers.
//   csa_layer_count() : CSA3T2 layers needed to reduce WIDTH+1 partial products to two rows.
package mul_pkg;

    localparam int unsigned MUL_MAX_STAGES = 6;

    typedef struct packed {
        logic in1_signed;
        logic in2_signed;
    } mul_sign_t;

    // Each layer turns every complete group of three rows into two; leftovers pass through.
    function automatic int unsigned csa_rows_after(input int unsigned rows,
                                                   input int unsigned layers);
        int unsigned n;
        n = rows;
        for (int unsigned i = 0; i < layers; i++) begin
            n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int unsigned csa_layer_count(input int unsigned width);
        int unsigned n;
        int unsigned layers;
        n      = width + 1;
        layers = 0;
        while (n > 2) begin
            n = n - n / 3;
            layers++;
        end
        return layers;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One register cut of the Wallace tree: NUM_LAYERS CSA3T2 layers followed by a row register
// and a valid flag. The last stage also performs the final carry-propagate add.
//   clk, rst   : clock, asynchronous active-high reset
//   advance    : stage may load (pipeline not stalled)
//   clear      : drop the valid flag (flush), higher priority than advance
//   valid_in   : incoming row set is a real operation
//   rows_in    : ROWS rows of LANES bits, only the lower IN_ROWS are meaningful
//   valid_out  : registered valid flag
//   rows_out   : registered rows, zero above the rows this stage produces
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int unsigned LANES      = 64,
    parameter int unsigned ROWS       = 33,
    parameter int unsigned IN_ROWS    = 33,
    parameter int unsigned NUM_LAYERS = 1,
    parameter bit          LAST       = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         advance,
    input  logic                         clear,
    input  logic                         valid_in,
    input  logic [ROWS-1:0][LANES-1:0]   rows_in,
    output logic                         valid_out,
    output logic [ROWS-1:0][LANES-1:0]   rows_out
);

    localparam int unsigned RED_ROWS = csa_rows_after(IN_ROWS, NUM_LAYERS);
    localparam int unsigned OUT_ROWS = LAST ? 1 : RED_ROWS;

    logic [ROWS-1:0][LANES-1:0]     reduced;
    logic [OUT_ROWS-1:0][LANES-1:0] rows_d;
    logic [OUT_ROWS-1:0][LANES-1:0] rows_q;
    logic                           valid_q;

    for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
        localparam int unsigned N = csa_rows_after(IN_ROWS, l);
        localparam int unsigned G = N / 3;

        logic [ROWS-1:0][LANES-1:0] cur;
        logic [ROWS-1:0][LANES-1:0] nxt;

        if (l == 0) begin : g_first
            assign cur = rows_in;
        end else begin : g_chain
            assign cur = g_layer[l-1].nxt;
        end

        if (N < ROWS) begin : g_spare
            logic unused_cur_rows;
            assign unused_cur_rows = ^cur[ROWS-1:N];
        end

        always_comb begin
            nxt = '0;
            for (int g = 0; g < int'(G); g++) begin
                nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                // Carry row: weight doubles, bit shifted past 2*WIDTH is discarded modulo.
                nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                              (cur[3*g+1] & cur[3*g+2])) << 1;
            end
            for (int r = 0; r < int'(N - 3 * G); r++) begin
                nxt[2*G+r] = cur[3*G+r];
            end
        end
    end

    if (NUM_LAYERS == 0) begin : g_pass
        assign reduced = rows_in;
    end else begin : g_tail
        assign reduced = g_layer[NUM_LAYERS-1].nxt;
    end

    if (RED_ROWS < ROWS) begin : g_red_spare
        logic unused_red_rows;
        assign unused_red_rows = ^reduced[ROWS-1:RED_ROWS];
    end

    if (LAST) begin : g_cpa
        // Final carry-propagate add of the (at most two) remaining rows.
        logic [LANES-1:0] sum;
        always_comb begin
            sum = '0;
            for (int r = 0; r < int'(RED_ROWS); r++) begin
                sum = sum + reduced[r];
            end
        end
        assign rows_d[0] = sum;
    end else begin : g_rows
        assign rows_d = reduced[OUT_ROWS-1:0];
    end

    // Rows load only for real operations so the final product holds across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rows_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_in;
            if (valid_in) begin
                rows_q <= rows_d;
            end
        end
    end

    assign valid_out = valid_q;

    always_comb begin
        rows_out               = '0;
        rows_out[OUT_ROWS-1:0] = rows_q;
    end

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined Wallace-tree multiplier with per-operand signedness (MUL/MULH/MULHSU/MULHU).
// Operands are captured at accept, then STAGES reduction stages follow, so an op accepted at
// edge N shows out_valid at edge N+STAGES when the consumer never stalls.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   in1, in2            : operands (WIDTH bits)
//   in1_signed/in2_sign : operand is two's complement
//   out_valid, out_ready: product handshake
//   out                 : full 2*WIDTH-bit product, holds its value across bubbles
//   flush               : only with MUL_FLUSH_EN defined; discards all in-flight ops
// Optional feature macro: MUL_FLUSH_EN.
module pipelined_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 in1_signed,
    input  logic                 in2_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MUL_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned PROD    = 2 * WIDTH;
    localparam int unsigned PP_ROWS = WIDTH + 1;
    localparam int unsigned LAYERS  = csa_layer_count(WIDTH);

    if (STAGES < 1 || STAGES > MUL_MAX_STAGES) begin : g_bad_stages
        $error("pipelined_multiplier: STAGES out of range");
    end

    logic      clear;
    logic      stall;
    logic      advance;
    mul_sign_t sign;

`ifdef MUL_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign sign     = {in1_signed, in2_signed};
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall & ~clear;

    // Operand capture: extend to WIDTH+1 bits so every sign mix is one signed multiply.
    logic             op_valid_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else if (clear) begin
            op_valid_q <= 1'b0;
        end else if (advance) begin
            op_valid_q <= in_valid;
            if (in_valid) begin
                a_q <= {sign.in1_signed & in1[WIDTH-1], in1};
                b_q <= {sign.in2_signed & in2[WIDTH-1], in2};
            end
        end
    end

    logic [PROD-1:0]               a_wide;
    logic [PP_ROWS-1:0][PROD-1:0]  pp_rows;

    assign a_wide = {{(WIDTH - 1){a_q[WIDTH]}}, a_q};

    always_comb begin
        pp_rows = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            pp_rows[j] = b_q[j] ? (a_wide << j) : '0;
        end
        // The extended multiplier's top bit has weight -2^WIDTH.
        pp_rows[WIDTH] = b_q[WIDTH] ? -(a_wide << WIDTH) : '0;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned L_BEFORE = (s * LAYERS) / STAGES;
        localparam int unsigned L_AFTER  = ((s + 1) * LAYERS) / STAGES;

        logic [PP_ROWS-1:0][PROD-1:0] rows_in;
        logic [PP_ROWS-1:0][PROD-1:0] rows_out;
        logic                         valid_in;
        logic                         valid_out;

        if (s == 0) begin : g_head
            assign rows_in  = pp_rows;
            assign valid_in = op_valid_q;
        end else begin : g_link
            assign rows_in  = g_stage[s-1].rows_out;
            assign valid_in = g_stage[s-1].valid_out;
        end

        mul_pipe_stage #(
            .LANES      (PROD),
            .ROWS       (PP_ROWS),
            .IN_ROWS    (csa_rows_after(PP_ROWS, L_BEFORE)),
            .NUM_LAYERS (L_AFTER - L_BEFORE),
            .LAST       (s == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .clear     (clear),
            .valid_in  (valid_in),
            .rows_in   (rows_in),
            .valid_out (valid_out),
            .rows_out  (rows_out)
        );
    end

    logic unused_out_rows;
    assign unused_out_rows = ^g_stage[STAGES-1].rows_out[PP_ROWS-1:1];

    assign out       = g_stage[STAGES-1].rows_out[0];
    assign out_valid = g_stage[STAGES-1].valid_out;

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 3;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in1        = '0;
    logic [WIDTH-1:0]  in2        = '0;
    logic              in1_signed = 1'b0;
    logic              in2_signed = 1'b0;
    logic              out_valid;
    logic              out_ready  = 1'b1;
    logic [63:0]       out;
`ifdef MUL_FLUSH_EN
    logic              flush      = 1'b0;
`endif

    pipelined_multiplier #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .in1_signed (in1_signed),
        .in2_signed (in2_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MUL_FLUSH_EN
        .flush      (flush),
`endif
        .out        (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
        bit          chk_lat;
    } entry_t;

    entry_t      sb[$];
    logic [63:0] next_exp = '0;
    bit          next_lat = 1'b0;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb_);
        logic [63:0] a64;
        logic [63:0] b64;
        a64 = sa  ? {{32{a[31]}}, a} : {32'b0, a};
        b64 = sb_ ? {{32{b[31]}}, b} : {32'b0, b};
        return a64 * b64;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: samples 1 time unit after the falling edge, when inputs are settled.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", out_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("product", out, e.exp);
                        if (e.chk_lat) check("latency", cyc - e.acc_cyc - 1, STAGES);
                    end
                end
`ifdef MUL_FLUSH_EN
                if (flush) sb.delete();
`endif
                if (in_valid && in_ready) sb.push_back('{next_exp, cyc, next_lat});
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sa,
                         input logic sb_, input logic [63:0] exp, input bit lat);
        @(negedge clk);
        in1        = a;
        in2        = b;
        in1_signed = sa;
        in2_signed = sb_;
        in_valid   = 1'b1;
        next_exp   = exp;
        next_lat   = lat;
    endtask

    task automatic drive_rand(input bit lat);
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb_;
        a   = $urandom;
        b   = $urandom;
        sa  = 1'($urandom_range(1));
        sb_ = 1'($urandom_range(1));
        drive(a, b, sa, sb_, model(a, b, sa, sb_), lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        bit filled;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out", out, 64'h0);
        check("reset_in_ready", in_ready, 1'b1);

        // Unsigned extreme, signed, MULHSU
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        idle(STAGES + 2);
        drive(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, 1'b1);
        drive(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        idle(STAGES + 2);

        // Back-to-back
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b1);
            #2;
            check("in_ready_b2b", in_ready, 1'b1);
        end
        idle(STAGES + 2);

        // Backpressure with a full pipe
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        filled    = 1'b0;
        for (int i = 0; i < 20 && !filled; i++) begin
            drive_rand(1'b0);
            #2;
            if (!in_ready) filled = 1'b1;
        end
        check("pipe_fill", filled, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) check("stall_out_stable", out, sb[0].exp);
        end
        drain();

        // Reset mid-flight
        for (int i = 0; i < 3; i++) drive_rand(1'b0);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < STAGES + 4; i++) begin
            @(negedge clk);
            #2;
            check("post_rst_no_valid", out_valid, 1'b0);
        end

`ifdef MUL_FLUSH_EN
        // Flush with two ops in flight and a beat offered
        drive_rand(1'b0);
        drive_rand(1'b0);
        drive_rand(1'b0);
        flush = 1'b1;
        #2;
        check("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES + 3; i++) begin
            @(negedge clk);
            #2;
            check("post_flush_no_valid", out_valid, 1'b0);
        end
        drive(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0000_0001_2340, 1'b1);
        idle(STAGES + 2);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1) == 1) begin
                drive_rand(1'b0);
            end else begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
        end
        drain();

        check("sb_empty_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
